// File: rtl/wb_irq_stage.sv
// RV32 write-back stage: retires MEM/WB, owns the machine CSRs, sequences traps/mret and arbitrates NUM_IRQ platform interrupts.
// rf write and irq_ack are combinational (0 cycles); flush/redirect are registered one cycle later; no backpressure, WB never stalls.
module wb_irq_stage #(
  parameter int unsigned        NUM_IRQ     = 4,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE    = {NUM_IRQ{1'b0}},
  parameter bit                 VECTORED_EN = 1'b1,
  parameter logic [31:0]        RESET_MTVEC = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_valid,
  input  logic [31:0]        wb_pc,
  input  logic [31:0]        wb_instr,
  input  logic [31:0]        wb_lsu_addr,
  input  logic [3:0]         wb_exc,
  input  logic               wb_mret,
  input  logic               wb_reg_wen,
  input  logic [4:0]         wb_reg_waddr,
  input  logic [31:0]        wb_reg_wdata,
  input  logic               csr_rd,
  input  logic [1:0]         csr_wr_op,
  input  logic [11:0]        csr_addr,
  input  logic [31:0]        csr_wdata,
  input  logic [NUM_IRQ-1:0] irq,
  output logic               rf_wen,
  output logic [4:0]         rf_waddr,
  output logic [31:0]        rf_wdata,
  output logic               flush,
  output logic [31:0]        redirect_pc,
  output logic [NUM_IRQ-1:0] irq_ack
);

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;
  state_t state_q, state_d;

  logic [NUM_IRQ-1:0] irq_q, edge_pend_q, mie_q;
  logic               mstatus_mie_q, mstatus_mpie_q;
  logic [31:0]        mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, redirect_q;

  logic [NUM_IRQ-1:0] pending, irq_enabled, irq_win_oh;
  logic [4:0]         irq_idx;
  logic               int_req;
  logic               take_int, take_exc, take_mret, retire, take_trap, csr_we;
  logic [31:0]        trap_cause, trap_tval, target_pc, mtvec_base;
  logic [31:0]        csr_rdata, csr_new, mtvec_legal, mip_rd, mie_rd;

  // Edge lines only see the latched flag; level lines follow the pin directly.
  assign pending     = (IRQ_EDGE & edge_pend_q) | (~IRQ_EDGE & irq);
  assign irq_enabled = pending & mie_q;
  assign int_req     = mstatus_mie_q & (|irq_enabled);

  always_comb begin
    irq_idx    = '0;
    irq_win_oh = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (irq_enabled[i]) begin
        irq_idx       = 5'(i);
        irq_win_oh    = '0;
        irq_win_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    mip_rd = '0;
    mie_rd = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      mip_rd[16+i] = pending[i];
      mie_rd[16+i] = mie_q[i];
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
      CSR_MIE:      csr_rdata = mie_rd;
      CSR_MIP:      csr_rdata = mip_rd;
      CSR_MTVEC:    csr_rdata = mtvec_q;
      CSR_MSCRATCH: csr_rdata = mscratch_q;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_MCAUSE:   csr_rdata = mcause_q;
      CSR_MTVAL:    csr_rdata = mtval_q;
      default:      csr_rdata = '0;
    endcase
  end

  always_comb begin
    case (csr_wr_op)
      2'b01:   csr_new = csr_wdata;
      2'b10:   csr_new = csr_rdata | csr_wdata;
      2'b11:   csr_new = csr_rdata & ~csr_wdata;
      default: csr_new = csr_rdata;
    endcase
    // Reserved modes (2,3) and disabled vectoring collapse to direct mode.
    mtvec_legal = {csr_new[31:2], (VECTORED_EN && csr_new[1:0] == 2'b01) ? 2'b01 : 2'b00};
  end

  always_comb begin
    trap_cause = '0;
    trap_tval  = '0;
    if (int_req) begin
      trap_cause = {1'b1, 26'b0, 5'd16 + irq_idx};
    end else if (wb_exc[0]) begin
      trap_cause = 32'd0;
      trap_tval  = wb_pc;
    end else if (wb_exc[1]) begin
      trap_cause = 32'd2;
      trap_tval  = wb_instr;
    end else if (wb_exc[2]) begin
      trap_cause = 32'd4;
      trap_tval  = wb_lsu_addr;
    end else if (wb_exc[3]) begin
      trap_cause = 32'd6;
      trap_tval  = wb_lsu_addr;
    end
  end

  assign mtvec_base = {mtvec_q[31:2], 2'b00};

  always_comb begin
    if (take_mret) begin
      target_pc = mepc_q;
    end else if (take_int && mtvec_q[1:0] == 2'b01) begin
      target_pc = mtvec_base + {25'b0, 5'd16 + irq_idx, 2'b00};
    end else begin
      target_pc = mtvec_base;
    end
  end

  always_comb begin
    state_d   = state_q;
    take_int  = 1'b0;
    take_exc  = 1'b0;
    take_mret = 1'b0;
    retire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wb_valid) begin
          if (int_req) begin
            take_int = 1'b1;
          end else if (|wb_exc) begin
            take_exc = 1'b1;
          end else if (wb_mret) begin
            take_mret = 1'b1;
          end else begin
            retire = 1'b1;
          end
          if (take_int || take_exc || take_mret) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    take_trap = take_int | take_exc;
    csr_we    = retire & (csr_wr_op != 2'b00);
    rf_wen    = retire & wb_reg_wen;
    rf_waddr  = wb_reg_waddr;
    rf_wdata  = csr_rd ? csr_rdata : wb_reg_wdata;
    irq_ack   = take_int ? irq_win_oh : '0;
  end

  assign flush       = (state_q == ST_FLUSH);
  assign redirect_pc = redirect_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      redirect_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_FLUSH) begin
        redirect_q <= target_pc;
      end
    end
  end

  // A new edge in the same cycle as its ack re-arms the line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q       <= '0;
      edge_pend_q <= '0;
    end else begin
      irq_q       <= irq;
      edge_pend_q <= ((edge_pend_q & ~irq_ack) | (irq & ~irq_q)) & IRQ_EDGE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= RESET_MTVEC;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else if (take_trap) begin
      mepc_q         <= {wb_pc[31:2], 2'b00};
      mcause_q       <= trap_cause;
      mtval_q        <= trap_tval;
      mstatus_mpie_q <= mstatus_mie_q;
      mstatus_mie_q  <= 1'b0;
    end else if (take_mret) begin
      mstatus_mie_q  <= mstatus_mpie_q;
      mstatus_mpie_q <= 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie_q  <= csr_new[3];
          mstatus_mpie_q <= csr_new[7];
        end
        CSR_MIE:      mie_q      <= csr_new[16 +: NUM_IRQ];
        CSR_MTVEC:    mtvec_q    <= mtvec_legal;
        CSR_MSCRATCH: mscratch_q <= csr_new;
        CSR_MEPC:     mepc_q     <= {csr_new[31:2], 2'b00};
        CSR_MCAUSE:   mcause_q   <= csr_new;
        CSR_MTVAL:    mtval_q    <= csr_new;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_irq_stage.sv
// Scoreboard bench for wb_irq_stage: a CSR/trap reference model queues expected rf writes, acks and redirects;
// a negedge monitor pops and compares them against what the stage presents.
module tb_wb_irq_stage;
  localparam int            NI       = 4;
  localparam logic [NI-1:0] EDGE     = 4'b0001;
  localparam logic [31:0]   RST_TVEC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wb_valid, wb_mret, wb_reg_wen, csr_rd;
  logic [31:0] wb_pc, wb_instr, wb_lsu_addr, wb_reg_wdata, csr_wdata;
  logic [3:0] wb_exc;
  logic [4:0] wb_reg_waddr;
  logic [1:0] csr_wr_op;
  logic [11:0] csr_addr;
  logic [NI-1:0] irq;
  logic rf_wen, flush;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata, redirect_pc;
  logic [NI-1:0] irq_ack;

  always #5 clk = ~clk;

  wb_irq_stage #(.NUM_IRQ(NI), .IRQ_EDGE(EDGE), .VECTORED_EN(1'b1), .RESET_MTVEC(RST_TVEC)) dut (
    .clk(clk), .rst(rst_n), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr),
    .wb_lsu_addr(wb_lsu_addr), .wb_exc(wb_exc), .wb_mret(wb_mret), .wb_reg_wen(wb_reg_wen),
    .wb_reg_waddr(wb_reg_waddr), .wb_reg_wdata(wb_reg_wdata), .csr_rd(csr_rd),
    .csr_wr_op(csr_wr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .irq(irq),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flush(flush),
    .redirect_pc(redirect_pc), .irq_ack(irq_ack));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [4:0] addr; logic [31:0] data; } rf_exp_t;
  typedef struct { int cyc; logic [31:0] pc; } fl_exp_t;
  typedef struct { int cyc; logic [NI-1:0] oh; } ack_exp_t;
  rf_exp_t  rf_q[$];
  fl_exp_t  fl_q[$];
  ack_exp_t ack_q[$];

  // Reference model state, in architectural terms.
  bit m_mie, m_mpie, m_flush;
  logic [NI-1:0] m_ien, m_epend, m_irq_prev;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;

  task automatic m_reset();
    m_mie = 0; m_mpie = 0; m_flush = 0;
    m_ien = '0; m_epend = '0; m_irq_prev = '0;
    m_mtvec = RST_TVEC; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
  endtask

  function automatic logic [NI-1:0] m_pending();
    return (EDGE & m_epend) | (~EDGE & irq);
  endfunction

  function automatic logic [31:0] m_csr(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
      12'h304: return 32'(m_ien) << 16;
      12'h344: return 32'(m_pending()) << 16;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      default: return 32'h0;
    endcase
  endfunction

  // Predict this cycle's response from the current inputs, advance the model, then step one clock.
  task automatic issue();
    logic [NI-1:0] pend, en, ack;
    logic [31:0] old, nv;
    int idx;
    rf_exp_t re;
    fl_exp_t fe;
    ack_exp_t ae;
    pend = m_pending();
    en = pend & m_ien;
    ack = '0;
    if (m_flush) begin
      m_flush = 0;
    end else if (wb_valid) begin
      if (m_mie && en != 0) begin
        idx = 0;
        while (!en[idx]) idx++;
        ack[idx] = 1'b1;
        ae.cyc = cyc; ae.oh = ack; ack_q.push_back(ae);
        fe.cyc = cyc + 1;
        fe.pc = (m_mtvec & ~32'h3) + ((m_mtvec[1:0] == 2'd1) ? 32'(4 * (16 + idx)) : 32'd0);
        fl_q.push_back(fe);
        m_mepc = wb_pc & ~32'h3; m_mcause = 32'h8000_0000 + 32'(16 + idx); m_mtval = 0;
        m_mpie = m_mie; m_mie = 0; m_flush = 1;
      end else if (wb_exc != 0) begin
        if (wb_exc[0]) begin m_mcause = 0; m_mtval = wb_pc; end
        else if (wb_exc[1]) begin m_mcause = 2; m_mtval = wb_instr; end
        else if (wb_exc[2]) begin m_mcause = 4; m_mtval = wb_lsu_addr; end
        else begin m_mcause = 6; m_mtval = wb_lsu_addr; end
        fe.cyc = cyc + 1; fe.pc = m_mtvec & ~32'h3; fl_q.push_back(fe);
        m_mepc = wb_pc & ~32'h3; m_mpie = m_mie; m_mie = 0; m_flush = 1;
      end else if (wb_mret) begin
        fe.cyc = cyc + 1; fe.pc = m_mepc; fl_q.push_back(fe);
        m_mie = m_mpie; m_mpie = 1; m_flush = 1;
      end else begin
        old = m_csr(csr_addr);
        if (wb_reg_wen) begin
          re.cyc = cyc; re.addr = wb_reg_waddr; re.data = csr_rd ? old : wb_reg_wdata;
          rf_q.push_back(re);
        end
        if (csr_wr_op != 2'b00) begin
          nv = (csr_wr_op == 2'b01) ? csr_wdata : (csr_wr_op == 2'b10) ? (old | csr_wdata) : (old & ~csr_wdata);
          case (csr_addr)
            12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
            12'h304: m_ien = nv[16 +: NI];
            12'h305: m_mtvec = (nv[1:0] == 2'd1) ? nv : (nv & ~32'h3);
            12'h340: m_mscratch = nv;
            12'h341: m_mepc = nv & ~32'h3;
            12'h342: m_mcause = nv;
            12'h343: m_mtval = nv;
            default: ;
          endcase
        end
      end
    end
    m_epend = ((m_epend & ~ack) | (irq & ~m_irq_prev)) & EDGE;
    m_irq_prev = irq;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; wb_pc = 0; wb_instr = 0; wb_lsu_addr = 0; wb_exc = 0; wb_mret = 0;
    wb_reg_wen = 0; wb_reg_waddr = 0; wb_reg_wdata = 0; csr_rd = 0; csr_wr_op = 0;
    csr_addr = 0; csr_wdata = 0;
  endtask

  task automatic nop();
    idle_inputs(); issue();
  endtask

  task automatic alu(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd);
    idle_inputs(); wb_valid = 1; wb_pc = pc; wb_reg_wen = 1; wb_reg_waddr = wa; wb_reg_wdata = wd; issue();
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd, input logic [4:0] rd);
    idle_inputs(); wb_valid = 1; wb_pc = 32'h1000; wb_reg_wen = 1; wb_reg_waddr = rd; csr_rd = 1;
    csr_wr_op = op; csr_addr = a; csr_wdata = wd; issue();
  endtask

  task automatic exc_instr(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] lsu, input logic [3:0] e);
    idle_inputs(); wb_valid = 1; wb_pc = pc; wb_instr = ins; wb_lsu_addr = lsu; wb_exc = e;
    wb_reg_wen = 1; wb_reg_waddr = 7; issue();
  endtask

  task automatic mret_instr(input logic [31:0] pc);
    idle_inputs(); wb_valid = 1; wb_pc = pc; wb_mret = 1; wb_reg_wen = 1; wb_reg_waddr = 9; issue();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  task automatic read_all_csrs();
    csr(2'b00, 12'h300, 0, 1); csr(2'b00, 12'h304, 0, 2); csr(2'b00, 12'h305, 0, 3);
    csr(2'b00, 12'h340, 0, 4); csr(2'b00, 12'h341, 0, 5); csr(2'b00, 12'h342, 0, 6);
    csr(2'b00, 12'h343, 0, 7); csr(2'b00, 12'h344, 0, 8);
  endtask

  rf_exp_t mr;
  fl_exp_t mf;
  ack_exp_t ma;
  always @(negedge clk) begin
    if (rst_n) begin
      while (rf_q.size() != 0 && rf_q[0].cyc < cyc) begin
        mr = rf_q.pop_front(); checks++; errors++;
        $display("FAIL rf_missing got no write, required waddr=%0d wdata=%h in cycle %0d", mr.addr, mr.data, mr.cyc);
      end
      while (fl_q.size() != 0 && fl_q[0].cyc < cyc) begin
        mf = fl_q.pop_front(); checks++; errors++;
        $display("FAIL flush_missing got no flush, required redirect %h in cycle %0d", mf.pc, mf.cyc);
      end
      while (ack_q.size() != 0 && ack_q[0].cyc < cyc) begin
        ma = ack_q.pop_front(); checks++; errors++;
        $display("FAIL ack_missing got none, required %b in cycle %0d", ma.oh, ma.cyc);
      end
      if (rf_wen) begin
        checks++;
        if (rf_q.size() == 0 || rf_q[0].cyc != cyc) begin
          errors++;
          $display("FAIL rf_unexpected got waddr=%0d wdata=%h, required no write (cycle %0d)", rf_waddr, rf_wdata, cyc);
        end else begin
          mr = rf_q.pop_front();
          if (rf_waddr !== mr.addr || rf_wdata !== mr.data) begin
            errors++;
            $display("FAIL rf_write got %0d/%h required %0d/%h", rf_waddr, rf_wdata, mr.addr, mr.data);
          end
        end
      end
      if (flush) begin
        checks++;
        if (fl_q.size() == 0 || fl_q[0].cyc != cyc) begin
          errors++;
          $display("FAIL flush_unexpected got flush redirect %h, required none (cycle %0d)", redirect_pc, cyc);
        end else begin
          mf = fl_q.pop_front();
          if (redirect_pc !== mf.pc) begin
            errors++;
            $display("FAIL redirect got %h required %h", redirect_pc, mf.pc);
          end
        end
      end
      if (irq_ack != 0) begin
        checks++;
        if (ack_q.size() == 0 || ack_q[0].cyc != cyc) begin
          errors++;
          $display("FAIL ack_unexpected got %b, required none (cycle %0d)", irq_ack, cyc);
        end else begin
          ma = ack_q.pop_front();
          if (irq_ack !== ma.oh) begin
            errors++;
            $display("FAIL ack got %b required %b", irq_ack, ma.oh);
          end
        end
      end
    end
  end

  logic [11:0] addr_tab [9] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7C0};

  initial begin
    idle_inputs();
    irq = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flush", 32'(flush), 0);
    chk("reset_redirect", redirect_pc, 0);
    chk("reset_ack", 32'(irq_ack), 0);
    chk("reset_rf_wen", 32'(rf_wen), 0);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Normal retire, then illegal instruction with MIE=1 so MPIE captures it.
    alu(32'h10, 5'd5, 32'hDEAD_BEEF);
    csr(2'b10, 12'h300, 32'h8, 1);
    exc_instr(32'h80, 32'hFFFF_FFFF, 32'h0, 4'b0010);
    alu(32'h84, 5'd6, 32'h1234);
    read_all_csrs();

    // Vectored priority: lines 1 and 2 pending and enabled, line 1 wins.
    csr(2'b01, 12'h305, 32'h201, 3);
    csr(2'b01, 12'h304, 32'h0006_0000, 3);
    irq = 4'b0110;
    csr(2'b10, 12'h300, 32'h8, 3);
    alu(32'h40, 5'd8, 32'h55);
    irq = 4'b0000;
    nop();
    read_all_csrs();

    // mret restores MIE; a valid instruction in the FLUSH cycle is dropped.
    csr(2'b01, 12'h341, 32'h84, 4);
    mret_instr(32'h90);
    alu(32'h94, 5'd10, 32'hAAAA);
    csr(2'b00, 12'h300, 0, 11);

    // Edge line latched while MIE=0, taken once MIE is set, cleared by the ack.
    csr(2'b01, 12'h300, 32'h0, 1);
    csr(2'b01, 12'h304, 32'h0001_0000, 1);
    irq = 4'b0001;
    nop();
    irq = 4'b0000;
    nop();
    nop();
    csr(2'b00, 12'h344, 0, 12);
    csr(2'b10, 12'h300, 32'h8, 13);
    alu(32'h100, 5'd14, 32'h77);
    nop();
    csr(2'b00, 12'h344, 0, 15);

    // Interrupt beats a simultaneous exception; reset lands in the FLUSH cycle.
    csr(2'b01, 12'h304, 32'h0004_0000, 1);
    irq = 4'b0100;
    csr(2'b10, 12'h300, 32'h8, 1);
    exc_instr(32'hC0, 32'h0, 32'h0, 4'b0010);
    rst_n = 0;
    #1;
    chk("reset_in_flush_flush", 32'(flush), 0);
    chk("reset_in_flush_redirect", redirect_pc, 0);
    rf_q.delete(); fl_q.delete(); ack_q.delete();
    irq = '0;
    idle_inputs();
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    read_all_csrs();

    for (int n = 0; n < 1500; n++) begin
      idle_inputs();
      if ($urandom_range(7) == 0) irq = irq ^ NI'(1 << $urandom_range(NI - 1));
      wb_valid = ($urandom_range(3) != 0);
      wb_pc = $urandom; wb_instr = $urandom; wb_lsu_addr = $urandom;
      case ($urandom_range(15))
        0: wb_exc = 4'($urandom_range(15, 1));
        1: wb_mret = 1;
        default: ;
      endcase
      wb_reg_wen = 1'($urandom_range(1));
      wb_reg_waddr = 5'($urandom);
      wb_reg_wdata = $urandom;
      if ($urandom_range(1) == 1) begin
        csr_rd = 1;
        csr_addr = addr_tab[$urandom_range(8)];
        csr_wr_op = 2'($urandom);
        csr_wdata = ($urandom_range(3) == 0) ? 32'h8 : $urandom;
      end
      issue();
    end

    repeat (3) nop();
    chk("drain_rf", 32'(rf_q.size()), 0);
    chk("drain_flush", 32'(fl_q.size()), 0);
    chk("drain_ack", 32'(ack_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_irq_stage.md
# wb_irq_stage

Parametrised RV32 write-back stage with an integrated machine-mode trap sequencer and a multi-line platform interrupt controller. It is the final pipeline stage. It retires the instruction presented by MEM/WB and drives the register-file write port. It owns the machine CSRs and decides exceptions, interrupts and mret. Every trap or mret becomes a registered one-cycle pipeline flush plus a redirect PC. Compared with the previous write-back stage it adds N configurable level/edge interrupt lines, per-line enables and priority, vectored mtvec mode, and explicit interrupt acknowledge.

## Interface
- NUM_IRQ, 4, number of platform interrupt lines (1..16); line i has cause 16+i
- IRQ_EDGE, {NUM_IRQ{1'b0}}, per-line mode: 1 = rising-edge latched, 0 = level
- VECTORED_EN, 1, 1 allows mtvec.MODE=1; 0 forces MODE to 0 on writes
- RESET_MTVEC, 32'h0, reset value of mtvec
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- wb_valid  in  1  an instruction is in WB this cycle
- wb_pc, wb_instr, wb_lsu_addr  in  32 each  PC, instruction word, load/store address
- wb_exc  in  4  bit0 instr-misaligned (cause 0), bit1 illegal (2), bit2 load-misaligned (4), bit3 store-misaligned (6)
- wb_mret  in  1  instruction is mret
- wb_reg_wen / wb_reg_waddr / wb_reg_wdata  in  1/5/32  GPR write request
- csr_rd  in  1  rd receives CSR read data
- csr_wr_op  in  2  00 none, 01 write, 10 set, 11 clear
- csr_addr / csr_wdata  in  12/32  CSR address and operand
- irq  in  NUM_IRQ  synchronous interrupt lines
- rf_wen / rf_waddr / rf_wdata  out  1/5/32  register-file write port
- flush  out  1  one-cycle pipeline flush
- redirect_pc  out  32  fetch target, valid while flush=1
- irq_ack  out  NUM_IRQ  one-hot pulse, line being serviced

## Operation
- CSRs implemented:
  - mstatus: MIE bit3, MPIE bit7, MPP[12:11] reads 2'b11.
  - mie (0x304): bits 16+i writable.
  - mip (0x344): bits 16+i = pending[i], read-only.
  - mtvec (0x305).
  - mscratch (0x340).
  - mepc (0x341): bits [1:0] read 0.
  - mcause (0x342).
  - mtval (0x343).
  - Any other address reads 0; writes to it are ignored.
- pending[i]:
  - Level line: pending[i] = irq[i].
  - Edge line: set on a registered rising edge (irq & ~irq_q), cleared by irq_ack[i]. A set in the same cycle as the ack wins.
- Interrupt request: int_req = mstatus.MIE & |(pending & mie[16+:NUM_IRQ]). The winner is the lowest enabled pending index.
- FSM state IDLE, evaluated when wb_valid=1, first match wins:
  - **Interrupt.** Conditions: int_req. Updates: mepc=wb_pc, mcause={1'b1, 31'(16+i)}, mtval=0, irq_ack[i] pulses this cycle. Target: mtvec.BASE + 4*(16+i) if MODE=1, else BASE.
  - **Exception.** Conditions: |wb_exc. The lowest set bit selects the cause. Updates: mepc=wb_pc, mcause={1'b0, cause}, mtval=wb_instr for illegal, wb_lsu_addr for load/store-misaligned, wb_pc for instr-misaligned. Target: BASE.
  - **mret.** Target: mepc. Updates: MIE<=MPIE, MPIE<=1.
  - **Otherwise.** The instruction retires normally.
- On a trap (interrupt or exception): MPIE<=MIE, MIE<=0.
- Any trap or mret moves the FSM IDLE->FLUSH.
- FLUSH lasts one cycle:
  - flush=1 and redirect_pc=target, both registered.
  - wb_valid is ignored: no rf write, no CSR write, no trap.
  - The FSM returns to IDLE.
- Squash rules:
  - Trapped instructions (interrupt or exception) produce rf_wen=0 and no CSR write.
  - mret produces no rf write.
- Normal retire:
  - rf_wen = wb_valid & wb_reg_wen.
  - rf_wdata = csr_rd ? current CSR value : wb_reg_wdata.
  - The CSR write uses the pre-write value with the selected op (set: old|wdata, clear: old&~wdata).
- mtvec writes: MODE bits with value 2 or 3 are stored as 0. MODE=1 is stored as 0 when VECTORED_EN=0.

## Timing
- rf_* is combinational from the WB inputs and current state, with zero latency.
- CSR writes and trap CSR updates commit at the rising edge that ends the decision cycle N.
- flush/redirect_pc are high in cycle N+1 only. They are never asserted back-to-back.
- irq_ack is combinational in cycle N, one cycle wide. The edge-pending clear is visible in mip from N+1.
- Reset values, asserted asynchronously:
  - FSM IDLE.
  - flush=0, redirect_pc=0, irq_ack=0, irq_q=0, pending=0.
  - mstatus MIE=MPIE=0.
  - mie, mepc, mcause, mtval, mscratch = 0.
  - mtvec = RESET_MTVEC.
- Reset asserted during FLUSH drops flush immediately. After release the FSM is IDLE.
- An edge on a masked line still latches pending. It is taken once enabled.

## Test plan
- **Normal retire.** wb_valid=1, wb_reg_wen=1, waddr=5, wdata=0xDEAD_BEEF -> rf_wen=1, rf_waddr=5, rf_wdata=0xDEAD_BEEF same cycle; flush stays 0.
- **Illegal instruction.** mtvec=0x100, wb_exc=4'b0010, wb_pc=0x80, wb_instr=0xFFFF_FFFF -> rf_wen=0; next cycle flush=1, redirect_pc=0x100, mcause=2, mepc=0x80, mtval=0xFFFF_FFFF, MIE=0, MPIE=old MIE.
- **Vectored priority.** mtvec=0x201 (MODE=1), MIE=1, mie bits 17 and 18 set, irq[1]=irq[2]=1, wb_pc=0x40 -> irq_ack=3'b010, mcause=0x8000_0011, redirect_pc=0x244, mepc=0x40.
- **Edge line.** IRQ_EDGE bit0=1, MIE=0, pulse irq[0] for one cycle -> mip bit16 stays 1. Set MIE via csrrs -> trap on the next valid instruction, irq_ack[0] pulses, mip bit16=0 afterward.
- **mret and FLUSH.** After a trap, mret with mepc=0x84 -> flush, redirect_pc=0x84, MIE restored, MPIE=1. A valid instruction with wb_reg_wen=1 during the FLUSH cycle -> rf_wen=0.
- **Simultaneous events and reset.** Interrupt and exception in the same cycle -> interrupt taken with mcause MSB=1. Assert rst during FLUSH -> flush=0 immediately and all CSRs return to reset values.
